// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the async FIFO write port: one requester
// per grant, bursts end on last, MAX_BURST beats or valid drop.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk_wr,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          found;
  logic          g_valid;
  logic          g_last;
  logic          beat;
  logic          done;

  // Walk downward so the nearest valid index after ptr wins.
  always_comb begin
    pick  = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign busy    = (state_q == S_GRANT);
  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign beat    = busy && g_valid && !fifo_full;
  assign done    = beat && (g_last || cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) req_ready[grant_q] = 1'b1;
  end

  assign fifo_wr_en   = beat;
  assign fifo_wr_data = busy ? req_data[grant_q*DATA_WIDTH +: DATA_WIDTH]
                             : '0;
  assign grant_id     = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (!g_valid || done) begin
          state_d = S_IDLE;
          ptr_d   = grant_q;
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
